// File: rtl/unsigned_calc_seq_v_if.sv
// Operand/result handshake bundle for unsigned_calc_seq_v.
// o_ovf is present only when CALC_SEQ_OVF_EN is defined.
interface unsigned_calc_seq_v_if;
  logic       i_valid;
  logic       o_ready;
  logic [3:0] i_au;
  logic [3:0] i_bu;
  logic [3:0] i_cu;
  logic       o_valid;
  logic       i_ready;
  logic [8:0] o_fu;
`ifdef CALC_SEQ_OVF_EN
  logic       o_ovf;
`endif

  modport master (
    output i_valid, i_au, i_bu, i_cu, i_ready,
`ifdef CALC_SEQ_OVF_EN
    input  o_ovf,
`endif
    input  o_ready, o_valid, o_fu
  );

  modport slave (
    input  i_valid, i_au, i_bu, i_cu, i_ready,
`ifdef CALC_SEQ_OVF_EN
    output o_ovf,
`endif
    output o_ready, o_valid, o_fu
  );
endinterface

// File: rtl/unsigned_calc_seq_v.sv
// Sequenced f = 7a - 3b + 6c on one shared 9-bit adder/subtractor, five ops per result.
// Optional overflow flag o_ovf enabled by defining CALC_SEQ_OVF_EN.
module unsigned_calc_seq_v (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  unsigned_calc_seq_v_if.slave bus
);
  localparam int unsigned W_OPND = 4;
  localparam int unsigned W_ACC  = 9;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_OP1  = 3'd1,
    S_OP2  = 3'd2,
    S_OP3  = 3'd3,
    S_OP4  = 3'd4,
    S_OP5  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [W_OPND-1:0]   r_a;
  logic [W_OPND-1:0]   r_b;
  logic [W_OPND-1:0]   r_c;
  logic [W_ACC-1:0]    r_acc;
  logic [W_ACC-1:0]    r_fu;
  logic [W_ACC-1:0]    w_opnd;
  logic                w_sub;
  logic [W_ACC-1:0]    w_sum;

  // Schedule: next state plus the operand/direction fed to the shared adder
  always_comb begin
    w_next = r_state;
    w_opnd = '0;
    w_sub  = 1'b0;
    case (r_state)
      S_IDLE: if (bus.i_valid) w_next = S_OP1;
      S_OP1: begin
        w_opnd = W_ACC'(r_a);
        w_sub  = 1'b1;
        w_next = S_OP2;
      end
      S_OP2: begin
        w_opnd = W_ACC'({r_b, 2'b00});
        w_sub  = 1'b1;
        w_next = S_OP3;
      end
      S_OP3: begin
        w_opnd = W_ACC'(r_b);
        w_next = S_OP4;
      end
      S_OP4: begin
        w_opnd = W_ACC'({r_c, 3'b000});
        w_next = S_OP5;
      end
      S_OP5: begin
        w_opnd = W_ACC'({r_c, 1'b0});
        w_sub  = 1'b1;
        w_next = S_DONE;
      end
      S_DONE:  if (bus.i_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Invert-and-carry-in subtraction; carry-out is dropped since no intermediate wraps
  assign w_sum = r_acc + (w_opnd ^ {W_ACC{w_sub}}) + W_ACC'(w_sub);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_c   <= '0;
      r_acc <= '0;
      r_fu  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_valid) begin
            r_a   <= bus.i_au;
            r_b   <= bus.i_bu;
            r_c   <= bus.i_cu;
            r_acc <= W_ACC'({bus.i_au, 3'b000});
          end
        end
        S_OP1, S_OP2, S_OP3, S_OP4: r_acc <= w_sum;
        S_OP5:                      r_fu  <= w_sum;
        default: ;
      endcase
    end
  end

`ifdef CALC_SEQ_OVF_EN
  logic r_ovf;

  // Result never drops below -128, so overflow is exactly a non-negative value above 127
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)               r_ovf <= 1'b0;
    else if (r_state == S_OP5)  r_ovf <= ~w_sum[W_ACC-1] & w_sum[W_ACC-2];
  end

  assign bus.o_ovf = r_ovf;
`endif

  assign bus.o_ready = (r_state == S_IDLE);
  assign bus.o_valid = (r_state == S_DONE);
  assign bus.o_fu    = r_fu;
endmodule
